// File: rtl/pipe_stage_reg.sv
// Single pipeline register stage driven by a shared stall vector, with flush,
// bubble insertion, hold, illegal-stall detection and saturating event counters.
module pipe_stage_reg #(
    parameter int WIDTH  = 64,
    parameter int STAGE  = 1,
    parameter int NSTALL = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTALL-1:0] stall,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        st,
    output logic [CNT_W-1:0]  hold_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_VALID = 2'd1,
        ST_HELD  = 2'd2
    } state_e;

    state_e            r_st;
    state_e            w_st_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [WIDTH-1:0]  r_data;
    logic [WIDTH-1:0]  w_data_nxt;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_err;
    logic              w_hold_ev;
    logic              w_bubble_ev;
    logic              w_flush_ev;
    logic              w_illegal;

    // Only our own stall bit and the downstream one matter.
    logic w_up_stall;
    logic w_dn_stall;
    logic w_unused_stall;
    assign w_up_stall     = stall[STAGE];
    assign w_dn_stall     = stall[STAGE+1];
    assign w_unused_stall = ^stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // NOTE: every signal gets a default before the priority chain so no path leaves it unassigned (no latch).
    always_comb begin
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_st_nxt    = r_st;
        w_hold_ev   = 1'b0;
        w_bubble_ev = 1'b0;
        w_flush_ev  = 1'b0;
        w_illegal   = 1'b0;
        if (flush) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = '0;
            w_st_nxt    = ST_EMPTY;
            w_flush_ev  = 1'b1;
        end else if (w_up_stall && !w_dn_stall) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = '0;
            w_st_nxt    = ST_EMPTY;
            w_bubble_ev = 1'b1;
        end else if (w_dn_stall) begin
            // Downstream stalled without us stalled is illegal but still must not overwrite.
            w_st_nxt    = (r_st == ST_EMPTY) ? ST_EMPTY : ST_HELD;
            w_hold_ev   = 1'b1;
            w_illegal   = !w_up_stall;
        end else begin
            w_valid_nxt = in_valid;
            w_data_nxt  = in_valid ? in_data : '0;
            w_st_nxt    = in_valid ? ST_VALID : ST_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_st         <= ST_EMPTY;
            r_hold_cnt   <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_st    <= w_st_nxt;
            if (clr_cnt) begin
                r_hold_cnt   <= '0;
                r_bubble_cnt <= '0;
                r_flush_cnt  <= '0;
                r_err        <= 1'b0;
            end else begin
                if (w_hold_ev)   r_hold_cnt   <= sat_inc(r_hold_cnt);
                if (w_bubble_ev) r_bubble_cnt <= sat_inc(r_bubble_cnt);
                if (w_flush_ev)  r_flush_cnt  <= sat_inc(r_flush_cnt);
                if (w_illegal)   r_err        <= 1'b1;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign st         = r_st;
    assign hold_cnt   = r_hold_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign err        = r_err;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance for function, a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_pipe_stage_reg;

    localparam int WIDTH  = 64;
    localparam int NSTALL = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NSTALL-1:0] stall;
    logic              flush;
    logic              clr_cnt;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;

    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [1:0]        st;
    logic [15:0]       hold_cnt;
    logic [15:0]       bubble_cnt;
    logic [15:0]       flush_cnt;
    logic              err;

    logic              s_out_valid;
    logic [7:0]        s_out_data;
    logic [1:0]        s_st;
    logic [1:0]        s_hold_cnt;
    logic [1:0]        s_bubble_cnt;
    logic [1:0]        s_flush_cnt;
    logic              s_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .st(st),
        .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .err(err)
    );

    pipe_stage_reg #(.WIDTH(8), .STAGE(1), .NSTALL(NSTALL), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data[7:0]),
        .out_valid(s_out_valid), .out_data(s_out_data), .st(s_st),
        .hold_cnt(s_hold_cnt), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt), .err(s_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; clr_cnt = 1'b0;
        in_valid = 1'b0; in_data = '0;
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_st", st, 0);
        check("rst_cnts", {hold_cnt, bubble_cnt, flush_cnt}, 0);
        check("rst_err", err, 0);

        // Load
        rst = 1'b0; in_valid = 1'b1; in_data = 64'hA5;
        tick();
        check("load_valid", out_valid, 1);
        check("load_data", out_data, 64'hA5);
        check("load_st", st, 1);

        // Hold 3 cycles with new data presented
        stall = 6'b000110; in_data = 64'h11;
        tick(); tick(); tick();
        check("hold_data", out_data, 64'hA5);
        check("hold_valid", out_valid, 1);
        check("hold_st", st, 2);
        check("hold_cnt3", hold_cnt, 3);

        // Flush beats a hold pattern
        flush = 1'b1;
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_data", out_data, 0);
        check("flush_st", st, 0);
        check("flush_cnt1", flush_cnt, 1);
        check("flush_hold_cnt", hold_cnt, 3);

        // Load then bubble
        flush = 1'b0; stall = '0; in_data = 64'h5A;
        tick();
        check("load2_data", out_data, 64'h5A);
        stall = 6'b000010;
        tick();
        check("bubble_valid", out_valid, 0);
        check("bubble_data", out_data, 0);
        check("bubble_st", st, 0);
        check("bubble_cnt1", bubble_cnt, 1);

        // Illegal pattern holds and sets err
        stall = '0;
        tick();
        stall = 6'b000100; in_data = 64'h33;
        tick();
        check("illegal_data", out_data, 64'h5A);
        check("illegal_err", err, 1);
        check("illegal_st", st, 2);
        check("illegal_hold_cnt", hold_cnt, 4);

        // Clear with an illegal event in the same cycle: nothing counted
        clr_cnt = 1'b1;
        tick();
        check("clr_err", err, 0);
        check("clr_cnts", {hold_cnt, bubble_cnt, flush_cnt}, 0);
        check("clr_payload", out_data, 64'h5A);

        // Load invalid, then load with stray stall bits set outside our pair
        clr_cnt = 1'b0; stall = '0; in_valid = 1'b0;
        tick();
        check("inval_valid", out_valid, 0);
        check("inval_data", out_data, 0);
        check("inval_st", st, 0);
        stall = 6'b111001; in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0077;
        tick();
        check("stray_data", out_data, 64'hDEAD_BEEF_0000_0077);
        check("stray_st", st, 1);

        // Hold while EMPTY stays EMPTY
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 6'b000110;
        tick();
        check("hold_empty_st", st, 0);
        check("hold_empty_cnt", hold_cnt, 1);

        // Saturation: both instances reset, load, hold 5
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = '0; in_data = 64'hC3;
        tick();
        check("sat_load", s_out_data, 8'hC3);
        stall = 6'b000110;
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold_cnt", s_hold_cnt, 3);
        check("wide_hold_cnt", hold_cnt, 5);
        check("sat_data", s_out_data, 8'hC3);

        // Reset mid-hold overrides flush and stall
        rst = 1'b1; flush = 1'b1;
        tick();
        check("midrst_valid", {out_valid, s_out_valid}, 0);
        check("midrst_data", out_data, 0);
        check("midrst_st", {st, s_st}, 0);
        check("midrst_cnts", {hold_cnt, bubble_cnt, flush_cnt, err}, 0);
        check("midrst_scnts", {s_hold_cnt, s_bubble_cnt, s_flush_cnt, s_err}, 0);

        // First post-reset load behaves as from EMPTY
        rst = 1'b0; flush = 1'b0; stall = '0; in_data = 64'h99;
        tick();
        check("post_valid", out_valid, 1);
        check("post_data", out_data, 64'h99);
        check("post_st", st, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 64: payload width in bits; legal range 1..256.
REQ-002 Parameter STAGE, default 1: index of the upstream stage in the stall vector; stall[STAGE+1] is the downstream stage.
REQ-003 Parameter NSTALL, default 6: stall vector width; STAGE SHALL satisfy 0 <= STAGE <= NSTALL-2.
REQ-004 Parameter CNT_W, default 16: width of each performance counter.
REQ-005 clk  input  1  rising-edge clock; the block SHALL use this single clock domain only.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 stall  input  NSTALL  pipeline stall vector; bit i high = stage i stalled.
REQ-008 flush  input  1  kill the stage contents at the next edge.
REQ-009 clr_cnt  input  1  synchronous clear of all counters and err.
REQ-010 in_valid  input  1  upstream payload valid.
REQ-011 in_data  input  WIDTH  upstream payload.
REQ-012 out_valid  output  1  registered payload valid.
REQ-013 out_data  output  WIDTH  registered payload.
REQ-014 st  output  2  stage state: 0 EMPTY, 1 VALID, 2 HELD.
REQ-015 hold_cnt, bubble_cnt, flush_cnt  output  CNT_W each  performance counters.
REQ-016 err  output  1  sticky flag: illegal stall pattern seen.

Function
REQ-017 All outputs SHALL be registered; latency in_data -> out_data SHALL be exactly one cycle when loading.
REQ-018 Per edge, the first true condition below SHALL decide the action (priority order REQ-019..REQ-023).
REQ-019 rst: see Reset section.
REQ-020 flush: out_valid<=0, out_data<=0, st<=EMPTY, flush_cnt increments; flush SHALL override any stall combination.
REQ-021 BUBBLE, stall[STAGE]=1 and stall[STAGE+1]=0: out_valid<=0, out_data<=0, st<=EMPTY, bubble_cnt increments.
REQ-022 HOLD, stall[STAGE+1]=1 (any stall[STAGE]): out_valid, out_data unchanged; st<=HELD if st was VALID or HELD, else stays EMPTY; hold_cnt increments.
REQ-023 LOAD, stall[STAGE]=0 and stall[STAGE+1]=0: out_valid<=in_valid, out_data<=in_valid ? in_data : 0, st<=in_valid ? VALID : EMPTY.
REQ-024 Stall pattern stall[STAGE]=0, stall[STAGE+1]=1 is illegal: SHALL act as HOLD (no overwrite) and set err<=1; err stays set until rst or clr_cnt.
REQ-025 st transitions only: EMPTY->VALID (load valid); VALID->HELD (hold); HELD->HELD (hold); VALID/HELD->VALID (load valid); any->EMPTY (flush, bubble, load invalid).
REQ-026 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 clr_cnt SHALL zero hold_cnt, bubble_cnt, flush_cnt, err on the next edge; an event in the same cycle SHALL NOT be counted; payload path unaffected.
REQ-028 Bits of stall outside STAGE and STAGE+1 SHALL have no effect.

Reset
REQ-029 On rst=1 at an edge: out_valid=0, out_data=0, st=EMPTY, all counters 0, err=0; rst SHALL override flush, clr_cnt and stall.
REQ-030 Reset asserted mid-hold SHALL discard the held payload; first post-reset load behaves as from EMPTY.

Verification
REQ-031 Load: STAGE=1, stall=0, in_valid=1, in_data=0xA5 -> next cycle out_valid=1, out_data=0xA5, st=1.
REQ-032 Hold: after REQ-031, stall=6'b000110 for 3 cycles, in_data=0x11 -> out_data stays 0xA5, st=2, hold_cnt=3.
REQ-033 Bubble: stall=6'b000010 one cycle -> out_valid=0, out_data=0, st=0, bubble_cnt=1.
REQ-034 Flush priority: flush=1 with stall=6'b000110 while holding 0xA5 -> out_valid=0, st=0, flush_cnt=1, hold_cnt unchanged.
REQ-035 Illegal pattern: stall=6'b000100 while holding 0x5A -> out_data=0x5A, err=1; then clr_cnt=1 -> err=0, all counters 0.
REQ-036 Saturation/reset: CNT_W=2, hold 5 cycles -> hold_cnt=3; rst=1 during hold -> all outputs 0 next cycle.
